// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Includes the digit-count legality check used at elaboration.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ        = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    // True when n decimal digits can hold every w-bit unsigned value.
    function automatic logic bcd_digits_fit(input int unsigned w, input int unsigned n);
        logic [127:0] cap;
        logic [127:0] max_val;
        cap = 128'd1;
        for (int unsigned i = 0; i < n; i++) begin
            cap = cap * 128'd10;
        end
        max_val = (128'd1 << w) - 128'd1;
        return (cap > max_val);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Conditional +3; result wraps within 4 bits and never carries out.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BCD_ADJ_THRESH) begin
            o_digit = i_digit + BCD_ADJ;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential W-bit binary to N-digit BCD converter (shift-and-add-3).
// One iteration per clock; results are published only on the final iteration.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 3
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bin_val,
    output logic         busy,
    output logic         done,
    output logic [3:0]   bcd_vals [N-1:0]
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    if (!bcd_digits_fit(W, N)) begin : g_param_check
        $error("bin_to_bcd_seq: N digits cannot represent all W-bit values");
    end

    b2b_state_t    r_state;
    b2b_state_t    w_state_nxt;
    logic [W-1:0]  r_bin;
    logic [CW-1:0] r_count;
    logic          r_busy;
    logic          r_done;
    logic          w_last_iter;
    bcd_digit_t    r_scratch  [N-1:0];
    bcd_digit_t    r_bcd_vals [N-1:0];
    bcd_digit_t    w_adj      [N-1:0];
    bcd_digit_t    w_shifted  [N-1:0];

    assign w_last_iter = (r_count == LAST_ITER);

    // Each digit is corrected, then the whole {scratch, bin} vector moves left one bit.
    for (genvar g = 0; g < N; g++) begin : g_digit
        bcd_add3 u_add3 (
            .i_digit (r_scratch[g]),
            .o_digit (w_adj[g])
        );
        if (g == 0) begin : g_lsd
            assign w_shifted[g] = {w_adj[g][2:0], r_bin[W-1]};
        end else begin : g_upper
            assign w_shifted[g] = {w_adj[g][2:0], w_adj[g-1][3]};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_last_iter) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status flags registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (w_state_nxt == DONE);
        end
    end

    // Conversion datapath: load on accept, iterate in SHIFT, publish on the last iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin   <= '0;
            r_count <= '0;
            for (int i = 0; i < N; i++) begin
                r_scratch[i]  <= 4'd0;
                r_bcd_vals[i] <= 4'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= bin_val;
                        r_count <= '0;
                        for (int i = 0; i < N; i++) begin
                            r_scratch[i] <= 4'd0;
                        end
                    end
                end
                SHIFT: begin
                    r_scratch <= w_shifted;
                    r_bin     <= r_bin << 1'b1;
                    r_count   <= r_count + CNT_ONE;
                    if (w_last_iter) begin
                        r_bcd_vals <= w_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_vals = r_bcd_vals;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: directed vectors on a W=8/N=3 instance
// and a W=4/N=2 instance, with monitors checking every done pulse and its timing.
module tb_bin_to_bcd_seq;

    logic       clk;
    logic       rst8, start8, busy8, done8;
    logic [7:0] bin8;
    logic [3:0] bcd8 [2:0];
    logic       rst4, start4, busy4, done4;
    logic [3:0] bin4;
    logic [3:0] bcd4 [1:0];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [11:0] digits;
        int          due;
    } exp8_t;
    typedef struct {
        logic [7:0] digits;
        int         due;
    } exp4_t;

    exp8_t q8 [$];
    exp4_t q4 [$];

    bin_to_bcd_seq #(.W(8), .N(3)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .bin_val(bin8),
        .busy(busy8), .done(done8), .bcd_vals(bcd8)
    );

    bin_to_bcd_seq #(.W(4), .N(2)) dut4 (
        .clk(clk), .reset(rst4), .start(start4), .bin_val(bin4),
        .busy(busy4), .done(done4), .bcd_vals(bcd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    function automatic logic [11:0] model8(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] model4(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Monitors: every done pulse must match the head of its scoreboard queue.
    always @(negedge clk) begin
        exp8_t e;
        if (rst8 === 1'b0 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut8_unexpected_done: got done with %h%h%h, required no done",
                         bcd8[2], bcd8[1], bcd8[0]);
            end else begin
                e = q8.pop_front();
                check("dut8_digits", {20'd0, bcd8[2], bcd8[1], bcd8[0]}, {20'd0, e.digits});
                check("dut8_done_cycle", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp4_t e;
        if (rst4 === 1'b0 && done4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut4_unexpected_done: got done with %h%h, required no done",
                         bcd4[1], bcd4[0]);
            end else begin
                e = q4.pop_front();
                check("dut4_digits", {24'd0, bcd4[1], bcd4[0]}, {24'd0, e.digits});
                check("dut4_done_cycle", cyc, e.due);
            end
        end
    end

    task automatic wait_idle8();
        int n = 0;
        while (busy8 !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("dut8_idle_timeout", {31'd0, busy8}, 32'd0);
    endtask

    // Called just after a negedge with dut8 idle; accept edge is the next posedge.
    task automatic issue8(input logic [7:0] v, input logic [11:0] exp);
        exp8_t e;
        start8 = 1'b1;
        bin8 = v;
        e.digits = exp;
        e.due = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    initial begin
        exp8_t e8;
        exp4_t e4;
        int base;
        int n;
        rst8 = 1'b0; rst4 = 1'b0;
        start8 = 1'b0; start4 = 1'b0;
        bin8 = 8'd0; bin4 = 4'd0;

        // Reset without any clock edge must clear outputs immediately.
        #2;
        rst8 = 1'b1; rst4 = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_bcd", {20'd0, bcd8[2], bcd8[1], bcd8[0]}, 32'd0);
        check("rst4_busy", {31'd0, busy4}, 32'd0);
        @(negedge clk);
        rst8 = 1'b0; rst4 = 1'b0;
        @(negedge clk);

        issue8(8'd255, 12'h255);
        wait_idle8();
        repeat (3) @(negedge clk);
        check("dut8_hold", {20'd0, bcd8[2], bcd8[1], bcd8[0]}, 32'h255);
        issue8(8'd0, 12'h000);
        wait_idle8();
        issue8(8'd100, 12'h100);
        wait_idle8();

        // Start during a conversion is ignored.
        issue8(8'd128, 12'h128);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        bin8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        bin8 = 8'd200;
        wait_idle8();
        repeat (4) @(negedge clk);
        issue8(8'd7, 12'h007);
        wait_idle8();

        // Reset mid-conversion aborts with no done pulse.
        issue8(8'd99, 12'h099);
        repeat (4) @(posedge clk);
        #2;
        rst8 = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_bcd", {20'd0, bcd8[2], bcd8[1], bcd8[0]}, 32'd0);
        q8.delete();
        @(negedge clk);
        rst8 = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_bcd_after", {20'd0, bcd8[2], bcd8[1], bcd8[0]}, 32'd0);
        issue8(8'd99, 12'h099);
        wait_idle8();

        // Start held high: exhaustive sweep, one conversion every 10 cycles.
        @(negedge clk);
        base = cyc;
        start8 = 1'b1;
        for (int v = 0; v < 256; v++) begin
            bin8 = 8'(v);
            e8.digits = model8(v);
            e8.due = base + 9 + 10 * v;
            q8.push_back(e8);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done8 !== 1'b1 && n < 20);
            if (done8 !== 1'b1) begin
                check("dut8_sweep_timeout", {31'd0, done8}, 32'd1);
            end
        end
        start8 = 1'b0;
        repeat (4) @(negedge clk);

        // W=4 sweep against the two-digit split, one conversion every 6 cycles.
        base = cyc;
        start4 = 1'b1;
        for (int v = 0; v < 16; v++) begin
            bin4 = 4'(v);
            e4.digits = model4(v);
            e4.due = base + 5 + 6 * v;
            q4.push_back(e4);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done4 !== 1'b1 && n < 12);
            if (done4 !== 1'b1) begin
                check("dut4_sweep_timeout", {31'd0, done4}, 32'd1);
            end
        end
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        check("dut4_last_hold", {24'd0, bcd4[1], bcd4[0]}, 32'h15);

        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", q8.size() + q4.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It accepts a W-bit unsigned value on a start pulse and converts it over W clock cycles. It then presents N registered BCD digits in the unpacked-array format consumed by `bcd_to_7_seg_n`. It sits directly upstream of the seven-segment decoder stage and replaces the compare-and-subtract digit split once values exceed two digits.

## Interface
Parameters:
- `W`, default 8: width of the binary input; must be ≥ 1.
- `N`, default 3: number of BCD digits output. Must satisfy 10^N > 2^W − 1; an elaboration-time assertion enforces this.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: request a conversion. Sampled only in IDLE.
- `bin_val` input W: unsigned value to convert; sampled on the edge that accepts `start`.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse; `bcd_vals` is updated and valid in that cycle.
- `bcd_vals` output `logic [3:0] bcd_vals [N-1:0]`: index 0 is the ones digit; held between conversions.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: performs W iterations.
  - DONE: one cycle, asserts `done`.
- IDLE:
  - On `start` = 1, load `bin` shift register ← `bin_val`, scratch digits ← 0, iteration count ← 0, and go to SHIFT.
  - On `start` = 0, stay in IDLE.
- SHIFT, each edge:
  - For every scratch digit ≥ 5, add 3. The result stays 4 bits, with no carry between digits.
  - Then shift `{scratch, bin}` left by 1; the MSB of `bin` enters bit 0 of digit 0.
  - Increment count.
- SHIFT exit: on the edge where count = W−1, perform the final iteration, write the post-shift scratch into `bcd_vals`, and go to DONE.
- DONE: `done` = 1; next edge → IDLE unconditionally.
- `start` while busy (SHIFT or DONE) is ignored, with no queuing; `bin_val` changes during conversion have no effect.
- `bcd_vals` changes only on the final SHIFT edge or on reset. Intermediate scratch values are never visible.
- Count register width: $clog2(W+1).
- Output arithmetic rules:
  - Every output digit is 0–9 for all legal inputs.
  - Digits above the most significant nonzero digit are 0; there is no blanking, which is the decoder's concern.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE
  - `busy` = 0
  - `done` = 0
  - all `bcd_vals` digits = 0
  - scratch, `bin` and count = 0
- Reset during SHIFT or DONE aborts the conversion: no `done` pulse, and `bcd_vals` returns to 0.
- Cycle sequence, with edge 0 being the edge that samples `start` = 1 in IDLE:
  - `busy` rises after edge 0.
  - Edges 1..W perform iterations.
  - `done` = 1 and the new `bcd_vals` are valid in the cycle after edge W.
  - `busy` falls after edge W+1.
- Latency from the accepting edge to `done`: W cycles.
- Throughput: one conversion per W+2 cycles. The earliest next accepted `start` is at edge W+2, with `start` held high or re-asserted.
- W = 1 case: a single SHIFT edge; the count = W−1 exit condition holds on the first SHIFT edge.
- `busy` and `done` are decoded from state only, with no combinational path from inputs.

## Structure
- Package `bcd_pkg`:
  - `typedef logic [3:0] bcd_digit_t`
  - constants `BCD_ADJ_THRESH = 4'd5` and `BCD_ADJ = 4'd3`
  - state enum `b2b_state_t {IDLE, SHIFT, DONE}`
- Sub-module `bcd_add3`: combinational, 4-bit in and 4-bit out; adds 3 when the input is ≥ 5. It is instantiated N times via generate.
- Top-level usage: `bcd_vals` connects directly to `bcd_to_7_seg_n #(.N(N)) .bcd_vals`.

## Test plan
- Reset asserted mid-cycle with no clock edge → immediately `busy` = 0, `done` = 0, `bcd_vals` = {0,0,0}.
- W=8, N=3:
  - `bin_val` = 255, start pulse → `done` exactly 8 cycles later with `bcd_vals[2:0]` = 2,5,5.
  - `bin_val` = 0 → `done` with 0,0,0.
  - `bin_val` = 100 → 1,0,0.
- W=8, N=3: `start` pulsed again, with `bin_val` = 7, in cycle 3 of a conversion of 128 → `bcd_vals` = 1,2,8, only one `done`. Then a new start with 7 → 0,0,7.
- W=8, N=3: `reset` pulsed after edge 4 of a conversion of 99 → no `done`, `bcd_vals` = 0. A subsequent start with 99 → 0,9,9.
- W=8, N=3, `start` held high continuously → `done` every 10 cycles; an exhaustive sweep of 0–255 matches the reference model (hundreds, tens, ones) for every value.
- W=4, N=2: sweep 0–15 → 15 gives 1,5 and 9 gives 0,9, matching the existing two-digit split for all 16 values.
